// File: rtl/rfphoenix_tlb_wb_responder_if.sv
// Bus bundle for the TLB write-back responder: the TLB-facing slave handshake
// (cyc/ack) plus the memory write port toward the data-side arbiter.
interface rfphoenix_tlb_wb_responder_if #(
    parameter int unsigned AWID = 32,
    parameter int unsigned DWID = 128
);
    logic            s_cyc_i;
    logic [AWID-1:0] s_adr_i;
    logic [DWID-1:0] s_dat_i;
    logic            s_ack_o;
    logic            mem_req_o;
    logic [AWID-1:0] mem_adr_o;
    logic [DWID-1:0] mem_dat_o;
    logic            mem_ack_i;

    // Responder side.
    modport slave (
        input  s_cyc_i, s_adr_i, s_dat_i, mem_ack_i,
        output s_ack_o, mem_req_o, mem_adr_o, mem_dat_o
    );

    // TLB and memory side, as seen by whoever drives the responder.
    modport master (
        output s_cyc_i, s_adr_i, s_dat_i, mem_ack_i,
        input  s_ack_o, mem_req_o, mem_adr_o, mem_dat_o
    );
endinterface

// File: rtl/rfphoenix_tlb_wb_responder.sv
// Acknowledges TLB dirty-entry write-backs into a small coalescing FIFO and
// drains them one at a time to the memory write port.
module rfphoenix_tlb_wb_responder #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AWID         = 32,
    parameter int unsigned DWID         = 128,
    parameter logic [15:0] WR_COUNT_RST = 16'h0000
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    rfphoenix_tlb_wb_responder_if.slave  bus,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         idle_o,
    output logic [15:0]                  wr_count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic { S_IDLE, S_ACK } slv_state_e;
    typedef enum logic { D_IDLE, D_REQ } drn_state_e;

    logic [AWID-1:0] fifo_adr [DEPTH];
    logic [DWID-1:0] fifo_dat [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    slv_state_e    slv_state_q, slv_state_d;
    drn_state_e    drn_state_q, drn_state_d;
    logic          ack_blank_q;
    logic          idle_q;
    logic [15:0]   wr_count_q;

    logic          push, pop, coalesce;
    logic          hit;
    logic [PW-1:0] hit_idx, cand_idx;
    logic          mem_req;

    // Coalesce lookup: walk from the head toward the tail so the youngest
    // match wins. The head is untouchable while it is being written out.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        hit      = 1'b0;
        hit_idx  = '0;
        cand_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cand_idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && !((k == 0) && (drn_state_q == D_REQ)) &&
                (fifo_adr[cand_idx] == bus.s_adr_i)) begin
                hit     = 1'b1;
                hit_idx = cand_idx;
            end
        end
    end

    always_comb begin
        slv_state_d = slv_state_q;
        push        = 1'b0;
        coalesce    = 1'b0;
        case (slv_state_q)
            S_IDLE: begin
                if (bus.s_cyc_i && !ack_blank_q) begin
                    if (hit) begin
                        coalesce    = 1'b1;
                        slv_state_d = S_ACK;
                    end else if (count_q < CW'(DEPTH)) begin
                        push        = 1'b1;
                        slv_state_d = S_ACK;
                    end
                end
            end
            S_ACK:   slv_state_d = S_IDLE;
            default: slv_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        drn_state_d = drn_state_q;
        pop         = 1'b0;
        case (drn_state_q)
            D_IDLE: if (count_q != '0) drn_state_d = D_REQ;
            D_REQ: begin
                if (bus.mem_ack_i) begin
                    pop         = 1'b1;
                    drn_state_d = D_IDLE;
                end
            end
            default: drn_state_d = D_IDLE;
        endcase
    end

    // Full is judged on the registered count, so a same-cycle pop never
    // makes room for a push.
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slv_state_q <= S_IDLE;
            drn_state_q <= D_IDLE;
            ack_blank_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            idle_q      <= 1'b1;
            wr_count_q  <= WR_COUNT_RST;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // sees the pre-edge values of the others.
            slv_state_q <= slv_state_d;
            drn_state_q <= drn_state_d;
            // The TLB keeps cyc high one cycle after it samples ack.
            ack_blank_q <= (slv_state_q == S_ACK);
            count_q     <= count_d;
            idle_q      <= (count_d == '0) && (drn_state_d == D_IDLE);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    // NOTE: the entry storage has no reset; pointers and count alone decide
    // which slots hold live write-backs.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_adr[wr_ptr_q] <= bus.s_adr_i;
            fifo_dat[wr_ptr_q] <= bus.s_dat_i;
        end else if (coalesce) begin
            fifo_dat[hit_idx] <= bus.s_dat_i;
        end
    end

    assign mem_req       = (drn_state_q == D_REQ);
    assign bus.s_ack_o   = (slv_state_q == S_ACK);
    assign bus.mem_req_o = mem_req;
    assign bus.mem_adr_o = mem_req ? fifo_adr[rd_ptr_q] : '0;
    assign bus.mem_dat_o = mem_req ? fifo_dat[rd_ptr_q] : '0;

    assign count_o    = count_q;
    assign idle_o     = idle_q;
    assign wr_count_o = wr_count_q;
endmodule
